// File: rtl/bram_arbiter.sv
// bram_arbiter: three-requester arbiter (display, sobel fetch, write-back) onto one BRAM port
// with display burst limiting, fetch/write-back round robin and a read-tag return pipeline.
module bram_arbiter #(
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 8,
  parameter int MAX_ADDR  = 291599,
  parameter int RD_LAT    = 2,
  parameter int BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arb_en_i,
  input  logic              disp_req_i,
  input  logic [ADDR_W-1:0] disp_addr_i,
  output logic              disp_gnt_o,
  output logic [DATA_W-1:0] disp_rdata_o,
  output logic              disp_rvalid_o,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic              fetch_gnt_o,
  output logic [DATA_W-1:0] fetch_rdata_o,
  output logic              fetch_rvalid_o,
  input  logic              wb_req_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              wb_gnt_o,
  output logic              ena_o,
  output logic              wea_o,
  output logic [ADDR_W-1:0] addra_o,
  output logic [DATA_W-1:0] dina_o,
  input  logic [DATA_W-1:0] douta_i,
  output logic              addr_err_o
);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int D  = RD_LAT + 1;
  typedef struct packed {
    logic v;
    logic own;
    logic err;
  } tag_t;
  logic [BW-1:0]     r_burst;
  logic              r_ptr;
  tag_t [D-1:0]      r_tag;
  tag_t              w_out;
  logic              w_en, w_others, w_sat, w_g0, w_g1, w_g2, w_any, w_oor;
  logic [ADDR_W-1:0] w_addr;
  assign w_en     = !rst && arb_en_i;
  assign w_others = fetch_req_i | wb_req_i;
  assign w_sat    = r_burst == BW'(BURST_MAX);
  assign w_g0     = w_en && disp_req_i && !(w_sat && w_others);
  // r_ptr=0 favours fetch, r_ptr=1 favours write-back
  assign w_g1     = w_en && !w_g0 && fetch_req_i && (!wb_req_i || !r_ptr);
  assign w_g2     = w_en && !w_g0 && wb_req_i && (!fetch_req_i || r_ptr);
  assign w_any    = w_g0 | w_g1 | w_g2;
  assign w_addr   = w_g0 ? disp_addr_i : w_g1 ? fetch_addr_i : wb_addr_i;
  assign w_oor    = w_addr > ADDR_W'(MAX_ADDR);
  assign disp_gnt_o  = w_g0;
  assign fetch_gnt_o = w_g1;
  assign wb_gnt_o    = w_g2;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_burst    <= '0;
      r_ptr      <= 1'b0;
      r_tag      <= '0;
      ena_o      <= 1'b0;
      wea_o      <= 1'b0;
      addra_o    <= '0;
      dina_o     <= '0;
      addr_err_o <= 1'b0;
    end else begin
      r_burst <= (w_g1 | w_g2 | !w_others) ? '0 : (w_g0 && !w_sat) ? r_burst + BW'(1) : r_burst;
      if (w_g1 | w_g2) r_ptr <= w_g1;
      ena_o <= w_any && !w_oor;
      wea_o <= w_g2 && !w_oor;
      if (w_any) begin
        addra_o <= w_addr;
        dina_o  <= w_g2 ? wb_data_i : '0;
      end
      if (w_any && w_oor) addr_err_o <= 1'b1;
      r_tag <= {r_tag[D-2:0], tag_t'{v: w_g0 | w_g1, own: w_g1, err: w_oor}};
    end
  end
  assign w_out          = r_tag[D-1];
  assign disp_rvalid_o  = !rst && w_out.v && !w_out.own;
  assign fetch_rvalid_o = !rst && w_out.v && w_out.own;
  assign disp_rdata_o   = (disp_rvalid_o && !w_out.err) ? douta_i : '0;
  assign fetch_rdata_o  = (fetch_rvalid_o && !w_out.err) ? douta_i : '0;
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed checks of bram_arbiter against a 2-cycle-latency BRAM model.
module tb_bram_arbiter;
  localparam int ADDR_W = 19, DATA_W = 8, MAX_ADDR = 291599;
  logic clk = 1'b0, rst, arb_en;
  logic disp_req, disp_gnt, disp_rvalid, fetch_req, fetch_gnt, fetch_rvalid, wb_req, wb_gnt;
  logic ena, wea, addr_err;
  logic [ADDR_W-1:0] disp_addr, fetch_addr, wb_addr, addra;
  logic [DATA_W-1:0] disp_rdata, fetch_rdata, wb_data, dina, douta, q1;
  logic [DATA_W-1:0] mem [0:MAX_ADDR];
  int n_checks = 0, n_err = 0;
  always #5 clk = ~clk;
  bram_arbiter dut (
    .clk(clk), .rst(rst), .arb_en_i(arb_en),
    .disp_req_i(disp_req), .disp_addr_i(disp_addr), .disp_gnt_o(disp_gnt),
    .disp_rdata_o(disp_rdata), .disp_rvalid_o(disp_rvalid),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_gnt_o(fetch_gnt),
    .fetch_rdata_o(fetch_rdata), .fetch_rvalid_o(fetch_rvalid),
    .wb_req_i(wb_req), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .wb_gnt_o(wb_gnt),
    .ena_o(ena), .wea_o(wea), .addra_o(addra), .dina_o(dina), .douta_i(douta),
    .addr_err_o(addr_err)
  );
  always @(posedge clk) begin
    if (ena) begin
      if (wea) mem[addra] <= dina;
      q1 <= mem[addra];
    end
    douta <= q1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i <= MAX_ADDR; i++) mem[i] = 8'(i);
    mem[100] = 8'h5A;
    mem[MAX_ADDR] = 8'h3C;
    q1 = '0;
    douta = '0;
    rst = 1'b1; arb_en = 1'b1;
    disp_req = 0; fetch_req = 0; wb_req = 0;
    disp_addr = '0; fetch_addr = '0; wb_addr = '0; wb_data = '0;
    tick; tick;
    check("rst_ena", ena, 0);
    check("rst_wea", wea, 0);
    check("rst_addra", addra, 0);
    check("rst_dina", dina, 0);
    check("rst_err", addr_err, 0);
    check("rst_rvalid", {disp_rvalid, fetch_rvalid}, 0);
    fetch_req = 1; #1;
    check("rst_gnt", fetch_gnt, 0);
    fetch_req = 0; rst = 0;
    tick;
    // single fetch read of address 100
    fetch_req = 1; fetch_addr = 100; #1;
    check("t1_fgnt", fetch_gnt, 1);
    check("t1_dwgnt", {disp_gnt, wb_gnt}, 0);
    tick; fetch_req = 0;
    check("t1_ena", ena, 1);
    check("t1_addra", addra, 100);
    check("t1_wea", wea, 0);
    check("t1_rv1", fetch_rvalid, 0);
    tick;
    check("t1_rv2", fetch_rvalid, 0);
    tick;
    check("t1_rv3", fetch_rvalid, 1);
    check("t1_rdata", fetch_rdata, 8'h5A);
    check("t1_drv", {disp_rvalid, disp_rdata}, 0);
    tick;
    check("t1_rv4", {fetch_rvalid, fetch_rdata}, 0);
    // display burst limit: 8 display grants then one fetch
    disp_req = 1; disp_addr = 10; fetch_req = 1; fetch_addr = 20;
    for (int i = 0; i < 18; i++) begin
      #1;
      check($sformatf("t2_dgnt%0d", i), disp_gnt, (i % 9) != 8);
      check($sformatf("t2_fgnt%0d", i), fetch_gnt, (i % 9) == 8);
      tick;
    end
    disp_req = 0; fetch_req = 0;
    repeat (4) tick;
    // fetch / write-back round robin from a fresh pointer
    rst = 1; tick; rst = 0;
    fetch_req = 1; fetch_addr = 100; wb_req = 1; wb_addr = 200; wb_data = 8'h77;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("t3_fgnt%0d", i), fetch_gnt, (i % 2) == 0);
      check($sformatf("t3_wgnt%0d", i), wb_gnt, (i % 2) == 1);
      tick;
      check($sformatf("t3_wea%0d", i), wea, (i % 2) == 1);
      check($sformatf("t3_ena%0d", i), ena, 1);
    end
    fetch_req = 0; wb_req = 0;
    repeat (4) tick;
    check("t3_mem", mem[200], 8'h77);
    // last valid address is in range
    disp_req = 1; disp_addr = ADDR_W'(MAX_ADDR); #1;
    check("t4_dgnt", disp_gnt, 1);
    tick; disp_req = 0;
    check("t4_ena", ena, 1);
    check("t4_err0", addr_err, 0);
    tick; tick;
    check("t4_drv", disp_rvalid, 1);
    check("t4_drdata", disp_rdata, 8'h3C);
    tick;
    // out-of-range write is granted but dropped
    wb_req = 1; wb_addr = ADDR_W'(MAX_ADDR + 1); wb_data = 8'hEE; #1;
    check("t4_wgnt", wb_gnt, 1);
    check("t4_err1", addr_err, 0);
    tick; wb_req = 0;
    check("t4_wena", ena, 0);
    check("t4_wwea", wea, 0);
    check("t4_err2", addr_err, 1);
    tick;
    check("t4_err3", addr_err, 1);
    check("t4_memkeep", mem[MAX_ADDR], 8'h3C);
    // out-of-range read returns zero at normal latency
    fetch_req = 1; fetch_addr = 300000; #1;
    check("t4_fgnt", fetch_gnt, 1);
    tick; fetch_req = 0;
    check("t4_rena", ena, 0);
    tick; tick;
    check("t4_frv", fetch_rvalid, 1);
    check("t4_frdata", fetch_rdata, 0);
    tick;
    check("t4_err4", addr_err, 1);
    // reset one cycle after a display grant kills the read
    disp_req = 1; disp_addr = 100; #1;
    check("t5_dgnt", disp_gnt, 1);
    tick; disp_req = 0; rst = 1; fetch_req = 1; #1;
    check("t5_gnt_rst", fetch_gnt, 0);
    tick;
    check("t5_ena", ena, 0);
    check("t5_wea", wea, 0);
    check("t5_addra", addra, 0);
    check("t5_dina", dina, 0);
    check("t5_err", addr_err, 0);
    check("t5_gnt", {disp_gnt, fetch_gnt, wb_gnt}, 0);
    check("t5_rv", {disp_rvalid, fetch_rvalid}, 0);
    rst = 0; fetch_req = 0;
    tick;
    check("t5_drv3", {disp_rvalid, disp_rdata}, 0);
    tick;
    check("t5_drv4", {disp_rvalid, disp_rdata}, 0);
    // arb_en drop blocks grants but lets the pipeline drain
    disp_req = 1; disp_addr = 100; fetch_req = 1; fetch_addr = 100;
    wb_req = 1; wb_addr = 200; wb_data = 8'h11; #1;
    check("t6_dgnt", {disp_gnt, fetch_gnt, wb_gnt}, 3'b100);
    tick; arb_en = 0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      check($sformatf("t6_gnt%0d", k), {disp_gnt, fetch_gnt, wb_gnt}, 0);
      check($sformatf("t6_ena%0d", k), ena, k == 1);
      check($sformatf("t6_drv%0d", k), disp_rvalid, k == 3);
      check($sformatf("t6_drd%0d", k), disp_rdata, (k == 3) ? 8'h5A : 8'h00);
      tick;
    end
    disp_req = 0; fetch_req = 0; wb_req = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, and SHALL sample reset only on the rising clock edge.
REQ-002 Parameter SHALL be: ADDR_W, 19, BRAM address width.
REQ-003 Parameter SHALL be: DATA_W, 8, pixel width.
REQ-004 Parameter SHALL be: MAX_ADDR, 291599, last valid address (540x540-1).
REQ-005 Parameter SHALL be: RD_LAT, 2, BRAM read latency from registered port to douta, 1..4.
REQ-006 Parameter SHALL be: BURST_MAX, 8, consecutive display grants allowed while others wait.
REQ-007 Port SHALL be: clk  in  1  rising-edge clock.
REQ-008 Port SHALL be: rst  in  1  synchronous active-high reset.
REQ-009 Port SHALL be: arb_en_i  in  1  grant enable; low blocks new grants.
REQ-010 Ports SHALL be: disp_req_i in 1, disp_addr_i in ADDR_W, disp_gnt_o out 1, disp_rdata_o out DATA_W, disp_rvalid_o out 1; display read requester (r0).
REQ-011 Ports SHALL be: fetch_req_i in 1, fetch_addr_i in ADDR_W, fetch_gnt_o out 1, fetch_rdata_o out DATA_W, fetch_rvalid_o out 1; sobel fetch read requester (r1).
REQ-012 Ports SHALL be: wb_req_i in 1, wb_addr_i in ADDR_W, wb_data_i in DATA_W, wb_gnt_o out 1; result write-back requester (r2).
REQ-013 Ports SHALL be: ena_o out 1, wea_o out 1, addra_o out ADDR_W, dina_o out DATA_W, douta_i in DATA_W; single BRAM port.
REQ-014 Port SHALL be: addr_err_o  out  1  sticky out-of-range flag.

Function
REQ-015 Handshake: requester SHALL hold req/addr/data stable until its gnt is high; the transfer occurs in the cycle gnt=1; gnt SHALL be combinational from req and arbiter state.
REQ-016 At most one gnt SHALL be high per cycle; no gnt SHALL be asserted while rst=1 or arb_en_i=0.
REQ-017 Priority: r0 SHALL win, except when burst_cnt==BURST_MAX and r1 or r2 is requesting; in that case r0 SHALL lose that cycle.
REQ-018 Between r1 and r2 a round-robin pointer SHALL select the winner; after an r1 or r2 grant the pointer SHALL point to the other requester.
REQ-019 burst_cnt SHALL increment on an r0 grant while r1|r2 is requesting (saturating at BURST_MAX), and SHALL clear on any r1/r2 grant or when r1 and r2 are both idle.
REQ-020 A granted access SHALL be registered to the BRAM port on the next edge: ena_o=1, wea_o=1 only for r2, addra_o/dina_o from the winner; with no grant, ena_o=wea_o=0 and addra_o/dina_o SHALL hold.
REQ-021 A tag pipeline of depth 1+RD_LAT SHALL carry {valid, owner}; read data SHALL appear on the owner's rdata with rvalid=1 exactly 1+RD_LAT cycles after the grant cycle, and SHALL be one cycle wide per grant.
REQ-022 rdata outputs SHALL be driven from douta_i when rvalid=1 and SHALL be 0 otherwise; back-to-back grants SHALL give back-to-back rvalid in grant order.
REQ-023 Address > MAX_ADDR: the request SHALL still be granted, with ena_o=0 (write dropped, no BRAM access); a read SHALL return rdata=0 with rvalid at the normal latency; addr_err_o SHALL set and stay set until reset.
REQ-024 arb_en_i falling SHALL NOT cancel accesses already in the tag pipeline; they SHALL drain normally.
REQ-025 Simultaneous r0/r1/r2 requests with burst_cnt<BURST_MAX SHALL grant r0 only.

Reset
REQ-026 While rst=1, outputs SHALL be: all gnt=0, ena_o=0, wea_o=0, addra_o=0, dina_o=0, all rvalid=0, all rdata=0, addr_err_o=0.
REQ-027 Reset SHALL set the round-robin pointer to r1, set burst_cnt=0, and clear the tag pipeline, so in-flight reads never produce rvalid.

Verification
REQ-028 The bench SHALL cover: r1 alone reads addr 100 (BRAM holds 0x5A), RD_LAT=2 -> fetch_gnt in cycle T, ena_o=1/addra_o=100 at T+1, fetch_rvalid with 0x5A at T+3.
REQ-029 The bench SHALL cover: r0 requests continuously with r1 requesting -> 8 disp grants, then 1 fetch grant, repeating.
REQ-030 The bench SHALL cover: r1 and r2 requesting continuously with r0 idle -> grants alternate r1, r2, r1, with wea_o=1 only on r2 cycles.
REQ-031 The bench SHALL cover: r2 writes addr 291600 -> wb_gnt=1, ena_o stays 0, addr_err_o=1 from the next cycle, BRAM contents unchanged.
REQ-032 The bench SHALL cover: r0 read granted, then rst pulsed 1 cycle later -> no disp_rvalid, and all outputs at reset values.
REQ-033 The bench SHALL cover: arb_en_i=0 with all requesters active -> no gnt; the reads granted before the drop return rvalid on schedule.
